reg16: RTL and testbench
========================

REG16 -- requirements
Module: reg16

Interface
Parameters:
REQ-001 The module SHALL expose parameter WIDTH, default 16, giving the data width in bits of d and q.
REQ-002 The module SHALL expose parameter RESET_VALUE, default 16'h0000 (WIDTH bits), giving the value q takes on reset.

Ports:
REQ-003 The module SHALL provide port CLK, input, 1 bit: the single clock; all state updates occur on its rising edge.
REQ-004 The module SHALL provide port RSTN, input, 1 bit: reset, asynchronous and active-low.
REQ-005 The module SHALL provide port d, input, WIDTH bits: data to be captured.
REQ-006 The module SHALL provide port load, input, 1 bit: capture enable, active-high.
REQ-007 The module SHALL provide port q, output, WIDTH bits: current register contents, driven directly from the storage flops.
REQ-008 The module SHALL have no other ports, so a bench connecting exactly q, d, load, CLK and RSTN leaves nothing unconnected.

Function
REQ-009 On a rising CLK edge with RSTN=1 and load=1, the register SHALL capture d, and q SHALL show the new value after that edge.
- Latency: 1 clock edge.
REQ-010 On a rising CLK edge with RSTN=1 and load=0, q SHALL hold its previous value, regardless of d.
REQ-011 q SHALL depend only on stored state: no combinational path from d, load or CLK level to q.
REQ-012 All WIDTH bits SHALL be captured in the same edge; partial-width updates are not permitted.
REQ-013 An unknown (X/Z) load SHALL NOT be treated as 1; any load value other than logic 1 SHALL hold q.
REQ-014 Changes to d or load between rising edges SHALL have no effect on q.
REQ-015 load SHALL be sampled only on the rising CLK edge; there is no other handshake and no busy/valid output.

Reset
REQ-016 When RSTN goes low, q SHALL become RESET_VALUE immediately, without waiting for a CLK edge.
REQ-017 While RSTN=0, q SHALL stay at RESET_VALUE, and CLK edges with load=1 SHALL be ignored.
REQ-018 If RSTN deasserts on or near a rising edge, that edge SHALL either capture d (when load=1) or leave RESET_VALUE; no other value is permitted.
REQ-019 From the first full rising edge after deassertion, normal operation per REQ-009/REQ-010 SHALL apply.
REQ-020 Asserting reset mid-operation SHALL discard the stored value with no hold-over.
REQ-021 With no reset applied since power-up, q SHALL be undefined until the first load.

Verification
REQ-022 Reset, then capture:
- RSTN=0 for 20 ns with load=1, d=16'hA5A5 -> q=16'h0000 throughout.
- Release RSTN; next rising edge with load=1, d=16'h1234 -> q=16'h1234.
REQ-023 Hold:
- After q=16'h1234, apply load=0 and change d each cycle (16'hFFFF, 16'h0001, random) for 3 edges -> q stays 16'h1234.
REQ-024 Periodic load, matching the standard bench pattern:
- CLK period 20 ns, d random every 20 ns, load high for 20 ns out of every 60 ns.
- -> q updates only at rising edges where load=1, taking the d sampled at that edge; compare against a reference model over 700 ns.
REQ-025 Asynchronous reset:
- With q=16'hBEEF, drive RSTN low at mid-cycle (between edges) -> q=16'h0000 within the same time step, before the next CLK edge.
REQ-026 Boundary values:
- Load 16'hFFFF, then 16'h0000, then 16'h8001 on consecutive edges -> q follows exactly, one edge latency each, with no bit stuck.
REQ-027 Parameter override:
- WIDTH=8, RESET_VALUE=8'h5A; reset -> q=8'h5A; load 8'hC3 -> q=8'hC3.

Source files
------------

// File: rtl/reg16.sv
// reg16: WIDTH-bit load-enabled data register with asynchronous active-low reset.
//
// Interface timing: load is a plain capture enable, not a handshake. It is
// sampled only on the rising CLK edge together with d. There is no valid/ready
// pair and no busy indication. The register accepts a new word on every edge
// where load is logic 1. Any other load value, including X or Z, holds q.
//
// q is taken straight from the storage flops. Nothing downstream sees a
// combinational path from d, load or the CLK level.
module reg16 #(
    parameter int unsigned           WIDTH       = 16,
    parameter logic [WIDTH-1:0]      RESET_VALUE = '0
) (
    input  logic             CLK,
    input  logic             RSTN,
    input  logic [WIDTH-1:0] d,
    input  logic             load,
    output logic [WIDTH-1:0] q
);

    // Storage for the full word. All bits update together on one edge.
    logic [WIDTH-1:0] data_r;

    // Capture d on a loaded edge. Reset forces RESET_VALUE at once, without waiting for CLK.
    always_ff @(posedge CLK or negedge RSTN) begin
        if (!RSTN) begin
            data_r <= RESET_VALUE;
        end else if (load == 1'b1) begin
            // In four-state simulation an X or Z load makes this test false,
            // so the register holds rather than capturing.
            data_r <= d;
        end
    end

    assign q = data_r;

endmodule

// File: tb/tb_reg16.sv
// tb_reg16: directed checks for reg16.
// Two instances are exercised: the default 16-bit one and an 8-bit one with a non-zero reset value.
module tb_reg16;

    logic        clk;
    logic        rstn;
    logic [15:0] d;
    logic        load;
    logic [15:0] q;
    logic [7:0]  d8;
    logic        load8;
    logic [7:0]  q8;

    int n_cmp  = 0;
    int n_fail = 0;

    logic [15:0] exp_q[$];
    logic [15:0] model;
    logic [15:0] want;

    reg16 dut (
        .CLK  (clk),
        .RSTN (rstn),
        .d    (d),
        .load (load),
        .q    (q)
    );

    reg16 #(.WIDTH(8), .RESET_VALUE(8'h5A)) dut8 (
        .CLK  (clk),
        .RSTN (rstn),
        .d    (d8),
        .load (load8),
        .q    (q8)
    );

    // Clock and watchdog.
    initial clk = 1'b0;
    always #10 clk = ~clk;

    initial begin
        #100000;
        $display("FAIL watchdog: observed timeout expected summary before 100000 ns");
        $fatal(1, "watchdog expired");
    end

    // Comparison point. The inputs are zero-extended, so one task serves both widths.
    task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] expv);
        n_cmp++;
        assert (obs === expv) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, expv);
        end
    endtask

    // Driver: apply inputs, then let one rising edge pass.
    // The task returns at the following falling edge.
    task automatic cycle(input logic l, input logic [15:0] v);
        load = l;
        d    = v;
        @(negedge clk);
    endtask

    initial begin
        rstn  = 1'b1;
        load  = 1'b0;
        d     = 16'h0000;
        load8 = 1'b0;
        d8    = 8'h00;

        // Reset held for 20 ns with load=1. The edge at 10 ns must be ignored.
        #2;
        rstn  = 1'b0;
        load  = 1'b1;
        d     = 16'hA5A5;
        load8 = 1'b1;
        d8    = 8'hFF;
        #1;
        check("reset_immediate", q, 16'h0000);
        check("reset_immediate_w8", {8'h00, q8}, 16'h005A);
        @(posedge clk); #1;
        check("reset_ignores_edge", q, 16'h0000);
        check("reset_ignores_edge_w8", {8'h00, q8}, 16'h005A);
        @(negedge clk);
        check("reset_hold_20ns", q, 16'h0000);

        // Release reset, then capture 1234 on the next edge.
        #2;
        rstn  = 1'b1;
        load8 = 1'b0;
        cycle(1'b1, 16'h1234);
        check("first_capture", q, 16'h1234);
        check("w8_held_without_load", {8'h00, q8}, 16'h005A);

        // Hold: load=0 while d changes each cycle.
        cycle(1'b0, 16'hFFFF);
        check("hold_ffff", q, 16'h1234);
        cycle(1'b0, 16'h0001);
        check("hold_0001", q, 16'h1234);
        cycle(1'b0, 16'($urandom_range(0, 16'hFFFF)));
        check("hold_random", q, 16'h1234);

        // A pulse on load and d between edges must not reach q.
        load = 1'b1;
        d    = 16'hDEAD;
        #3;
        load = 1'b0;
        d    = 16'h0BAD;
        @(negedge clk);
        check("glitch_between_edges", q, 16'h1234);

        // An unknown load value holds q.
        load = 1'bx;
        d    = 16'h5555;
        @(negedge clk);
        check("x_load_holds", q, 16'h1234);

        // 8-bit instance capture.
        load8 = 1'b1;
        d8    = 8'hC3;
        cycle(1'b0, 16'h0000);
        check("w8_capture_c3", {8'h00, q8}, 16'h00C3);
        load8 = 1'b0;

        // Boundary values on consecutive edges, one edge of latency each.
        load = 1'b1;
        d    = 16'hFFFF;
        #1;
        check("no_comb_path", q, 16'h1234);
        @(negedge clk);
        check("boundary_ffff", q, 16'hFFFF);
        cycle(1'b1, 16'h0000);
        check("boundary_0000", q, 16'h0000);
        cycle(1'b1, 16'h8001);
        check("boundary_8001", q, 16'h8001);

        // Periodic load: load is high for one cycle in every three, with random d each cycle, for 35 cycles (700 ns).
        model = q;
        for (int i = 0; i < 35; i++) begin
            load = (i % 3 == 0);
            d    = 16'($urandom_range(0, 16'hFFFF));
            if (load) model = d;
            exp_q.push_back(model);
            @(negedge clk);
            want = exp_q.pop_front();
            check("periodic", q, want);
        end

        // Asynchronous reset asserted mid-cycle from BEEF.
        cycle(1'b1, 16'hBEEF);
        check("load_beef", q, 16'hBEEF);
        load8 = 1'b1;
        d8    = 8'h11;
        #5;
        rstn = 1'b0;
        #1;
        check("async_reset_midcycle", q, 16'h0000);
        check("async_reset_w8", {8'h00, q8}, 16'h005A);
        @(posedge clk); #1;
        check("reset_blocks_load", q, 16'h0000);

        // After release, normal operation resumes.
        @(negedge clk);
        rstn  = 1'b1;
        load8 = 1'b0;
        cycle(1'b1, 16'h3C3C);
        check("after_reset_capture", q, 16'h3C3C);
        cycle(1'b0, 16'h0F0F);
        check("after_reset_hold", q, 16'h3C3C);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
